// File: rtl/usb_tx_arb_pkg.sv
// Shared definitions for the USB TX arbiter.
//   arb_state_t : frame FSM states (IDLE, SYNC, HDR, PAY, CRC)
//   HDR_*_W     : header field widths, HDR = {chan[3:0], len-1[3:0]}
//   LEN_W       : width of the burst length and payload counter (covers 1..16)
//   crc8_step   : one-byte update of CRC-8, poly 0x07, MSB first
// The CRC state and crc8_step are only used when USB_TX_ARB_CRC_EN is defined.
package usb_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    HDR  = 3'd2,
    PAY  = 3'd3,
    CRC  = 3'd4
  } arb_state_t;

  localparam int HDR_CHAN_W = 4;
  localparam int HDR_LEN_W  = 4;
  localparam int LEN_W      = 5;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : one request bit per channel
//   ptr   : last granted channel; search starts at ptr+1 and wraps modulo NCH
//   found : at least one request is set
//   idx   : first requesting channel in search order (0 when none)
module usb_rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [3:0]     ptr,
  output logic           found,
  output logic [3:0]     idx
);

  int best_d;
  int d;

  // Each channel's distance from ptr+1 in wrap order; the closest requester wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    best_d = NCH;
    d      = 0;
    for (int i = 0; i < NCH; i++) begin
      d = ((i - int'(ptr) - 1) % NCH + NCH) % NCH;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        found  = 1'b1;
        idx    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Shares one 8-bit USB TX byte stream among NCH producer channels.
// Round-robin grant; each grant sends one frame: SYNC_BYTE, HDR={chan,len-1},
// then len payload bytes popped from the granted channel.
// Optional build macro USB_TX_ARB_CRC_EN appends a CRC-8 byte (poly 0x07,
// init 0x00, MSB first) computed over HDR and payload.
// Ports:
//   clk, rstn : clock (tx_clk), asynchronous active-low reset
//   ch_cnt    : bytes guaranteed available per channel, ch i at [i*CNT_W +: CNT_W]
//   ch_data   : per-channel head byte, ch i at [i*8 +: 8]
//   ch_valid  : per-channel head byte valid
//   ch_ready  : per-channel pop strobe (one-hot or zero)
//   out_valid, out_ready, out_data : byte stream towards ftdi_245fifo tx_*
//   busy      : FSM not in IDLE
//   gnt_chan  : channel of the current or last frame
// Handshake: a byte moves on a cycle where valid and ready are both high;
// while out_valid is high and out_ready low the byte offered stays unchanged.
// In PAY the granted channel sees ch_ready = out_ready and the byte moves
// when its ch_valid is also high; a low ch_valid only stalls the frame.
module usb_tx_arbiter
  import usb_tx_arb_pkg::*;
#(
  parameter int         NCH       = 4,
  parameter int         MAX_BURST = 16,
  parameter int         CNT_W     = 11,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCH*CNT_W-1:0] ch_cnt,
  input  logic [NCH*8-1:0]     ch_data,
  input  logic [NCH-1:0]       ch_valid,
  output logic [NCH-1:0]       ch_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 busy,
  output logic [3:0]           gnt_chan
);

  arb_state_t        state;
  arb_state_t        state_n;
  logic [3:0]        ptr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  count;

  logic [NCH-1:0]    eligible;
  logic              pick_found;
  logic [3:0]        pick_idx;
  logic [CNT_W-1:0]  pick_cnt;
  logic [LEN_W-1:0]  pick_len;

  logic              sel_valid;
  logic [7:0]        sel_data;
  logic [7:0]        hdr_byte;
  logic              grant;
  logic              pay_xfer;
`ifdef USB_TX_ARB_CRC_EN
  logic [7:0]        crc;
  logic              hdr_xfer;
`endif

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = |ch_cnt[i*CNT_W +: CNT_W];
    end
  end

  usb_rr_pick #(.NCH(NCH)) u_pick (
    .req   (eligible),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Burst length of the winning channel, clamped; any remainder waits for its next turn.
  always_comb begin
    pick_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_idx == 4'(i)) pick_cnt = ch_cnt[i*CNT_W +: CNT_W];
    end
    if (pick_cnt > CNT_W'(MAX_BURST)) pick_len = LEN_W'(MAX_BURST);
    else                              pick_len = LEN_W'(pick_cnt);
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_chan == 4'(i)) begin
        sel_valid = ch_valid[i];
        sel_data  = ch_data[i*8 +: 8];
      end
    end
  end

  assign hdr_byte = {gnt_chan[HDR_CHAN_W-1:0], HDR_LEN_W'(len - LEN_W'(1))};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    out_valid = 1'b0;
    out_data  = '0;
    ch_ready  = '0;
    grant     = 1'b0;
    pay_xfer  = 1'b0;
`ifdef USB_TX_ARB_CRC_EN
    hdr_xfer  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant   = 1'b1;
          state_n = SYNC;
        end
      end
      SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
        if (out_ready) state_n = HDR;
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_byte;
`ifdef USB_TX_ARB_CRC_EN
        hdr_xfer  = out_ready;
`endif
        if (out_ready) state_n = PAY;
      end
      PAY: begin
        out_valid = sel_valid;
        out_data  = sel_data;
        for (int i = 0; i < NCH; i++) begin
          if (gnt_chan == 4'(i)) ch_ready[i] = out_ready;
        end
        pay_xfer = sel_valid & out_ready;
        if (pay_xfer && (count == len - LEN_W'(1))) begin
`ifdef USB_TX_ARB_CRC_EN
          state_n = CRC;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef USB_TX_ARB_CRC_EN
      CRC: begin
        out_valid = 1'b1;
        out_data  = crc;
        if (out_ready) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= 4'(NCH - 1);
      gnt_chan <= '0;
      len      <= '0;
      count    <= '0;
    end else if (grant) begin
      ptr      <= pick_idx;
      gnt_chan <= pick_idx;
      len      <= pick_len;
      count    <= '0;
    end else if (pay_xfer) begin
      count    <= count + LEN_W'(1);
    end
  end

`ifdef USB_TX_ARB_CRC_EN
  // SYNC is excluded: the running CRC is seeded from the header byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         crc <= '0;
    else if (grant)    crc <= '0;
    else if (hdr_xfer) crc <= crc8_step(8'h00, hdr_byte);
    else if (pay_xfer) crc <= crc8_step(crc, sel_data);
  end
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: per-channel producer memories feed the DUT, a
// frame-level model fills an expected byte queue, and one compare process
// checks every accepted output byte plus the handshake rules each cycle.
module tb_usb_tx_arbiter;

  localparam int NCH       = 4;
  localparam int MAX_BURST = 16;
  localparam int CNT_W     = 11;
  localparam int MEM_D     = 1024;
`ifdef USB_TX_ARB_CRC_EN
  localparam int FE = 1;
`else
  localparam int FE = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NCH*CNT_W-1:0] ch_cnt    = '0;
  logic [NCH*8-1:0]     ch_data   = '0;
  logic [NCH-1:0]       ch_valid  = '0;
  logic [NCH-1:0]       ch_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [7:0]           out_data;
  logic                 busy;
  logic [3:0]           gnt_chan;

  usb_tx_arbiter #(.NCH(NCH), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ch_cnt    (ch_cnt),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .gnt_chan  (gnt_chan)
  );

  // ---------------- bench state ----------------
  logic [7:0]     mem [NCH][MEM_D];
  int             head [NCH];
  int             tail [NCH];
  int             pop_total [NCH];
  int             ready_cycles [NCH];
  int             cap       = 1 << 20;
  int             rdy_mode  = 0;
  bit             vld_drop  = 1'b0;
  logic [NCH-1:0] pop_mask  = '0;
  logic [NCH-1:0] pm;
  logic [11:0]    exp_q [$];
  logic [7:0]     got_log [$];
  logic [11:0]    e;
  int             vec       = 0;
  int             miss      = 0;
  int             model_ptr = NCH - 1;
  bit             prev_stall = 1'b0;
  logic [7:0]     prev_data  = '0;
  int             snap;

  task automatic chk(input string name, input int got, input int want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_byte(input int ch, input logic [7:0] b);
    mem[ch][tail[ch]] = b;
    tail[ch]++;
  endtask

  // Frame-level model: walk the channels in round-robin order from the last
  // grant and emit whole frames until every producer is drained.
  task automatic build_expected();
    int rem [NCH];
    int hd [NCH];
    int c, cc, len;
    bit found;
    logic [7:0] b, crc, hdr;
    for (int i = 0; i < NCH; i++) begin
      hd[i]  = head[i];
      rem[i] = tail[i] - head[i];
    end
    forever begin
      found = 1'b0;
      c     = 0;
      for (int k = 1; k <= NCH; k++) begin
        cc = (model_ptr + k) % NCH;
        if (!found && rem[cc] > 0) begin
          found = 1'b1;
          c     = cc;
        end
      end
      if (!found) break;
      len = rem[c];
      if (len > cap) len = cap;
      if (len > MAX_BURST) len = MAX_BURST;
      hdr = 8'(c * 16 + len - 1);
      exp_q.push_back({4'(c), 8'hA5});
      exp_q.push_back({4'(c), hdr});
      crc = crc_ref(8'h00, hdr);
      for (int j = 0; j < len; j++) begin
        b = mem[c][hd[c]];
        hd[c]++;
        rem[c]--;
        exp_q.push_back({4'(c), b});
        crc = crc_ref(crc, b);
      end
`ifdef USB_TX_ARB_CRC_EN
      exp_q.push_back({4'(c), crc});
`endif
      model_ptr = c;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && !busy && all_empty())) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_timeout"}, int'(n < budget), 1);
    repeat (3) @(negedge clk);
    #1 chk({name, "_idle_after"}, int'(busy), 0);
  endtask

  task automatic lit(input string name, input int idx, input logic [7:0] want);
    if (idx < got_log.size()) chk(name, got_log[idx], want);
    else chk({name, "_missing"}, idx, -1);
  endtask

  task automatic start_test();
    got_log.delete();
    snap = ready_cycles[0];
  endtask

  // Producer: pops what the DUT took at the last edge, then re-presents heads.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (pop_mask[i]) begin
        head[i]++;
        pop_total[i]++;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      int n;
      n = tail[i] - head[i];
      if (n > cap) n = cap;
      ch_cnt[i*CNT_W +: CNT_W] = CNT_W'(n);
      ch_data[i*8 +: 8]        = (head[i] < tail[i]) ? mem[i][head[i]] : 8'h00;
      ch_valid[i]              = (head[i] < tail[i]) && (!vld_drop || $urandom_range(0, 3) != 0);
    end
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      pop_mask   = '0;
      prev_stall = 1'b0;
    end else begin
      chk("ready_onehot", int'($countones(ch_ready) <= 1), 1);
      chk("ready_chan", int'(ch_ready == '0 || ch_ready == (NCH'(1) << gnt_chan)), 1);
      if (out_valid) chk("busy_with_valid", int'(busy), 1);
      if (prev_stall && out_valid) chk("hold_data", out_data, prev_data);
      for (int i = 0; i < NCH; i++) begin
        pm[i] = ch_ready[i] & ch_valid[i];
        if (pm[i])
          chk("pop_ctx", int'(out_valid && out_ready && gnt_chan == 4'(i) && out_data == ch_data[i*8 +: 8]), 1);
        ready_cycles[i] += int'(ch_ready[i]);
      end
      pop_mask = pm;
      if (out_valid && out_ready) begin
        got_log.push_back(out_data);
        if (exp_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL extra_byte got=%0h want=none at %0t", {gnt_chan, out_data}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("stream", {gnt_chan, out_data}, e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, n;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_gnt_chan", gnt_chan, 0);
    @(posedge clk); #2 rstn = 1'b1;

    // Round robin from reset pointer: ch0,ch2,ch3 one byte per turn, ch1 empty.
    start_test();
    cap = 1;
    push_byte(0, 8'hA0); push_byte(0, 8'hA1);
    push_byte(2, 8'hC0); push_byte(2, 8'hC1);
    push_byte(3, 8'hD0); push_byte(3, 8'hD1);
    build_expected();
    drain("rr", 500);
    lit("rr_hdr0", 1, 8'h00);
    lit("rr_hdr1", 1 + 1 * (3 + FE), 8'h20);
    lit("rr_hdr2", 1 + 2 * (3 + FE), 8'h30);
    lit("rr_hdr3", 1 + 3 * (3 + FE), 8'h00);
    lit("rr_hdr4", 1 + 4 * (3 + FE), 8'h20);
    lit("rr_hdr5", 1 + 5 * (3 + FE), 8'h30);
    chk("rr_len", got_log.size(), 6 * (3 + FE));
    cap = 1 << 20;

    // Basic frame: ch0 three bytes.
    start_test();
    push_byte(0, 8'h10); push_byte(0, 8'h11); push_byte(0, 8'h12);
    build_expected();
    drain("basic", 300);
    lit("basic_b0", 0, 8'hA5);
    lit("basic_b1", 1, 8'h02);
    lit("basic_b2", 2, 8'h10);
    lit("basic_b3", 3, 8'h11);
    lit("basic_b4", 4, 8'h12);
    chk("basic_len", got_log.size(), 5 + FE);
    chk("basic_ready_pulses", ready_cycles[0] - snap, 3);

    // Clamp: ch1 forty bytes -> 16,16,8.
    start_test();
    for (int i = 0; i < 40; i++) push_byte(1, 8'(8'h80 + i));
    build_expected();
    drain("clamp", 1000);
    lit("clamp_hdr0", 1, 8'h1F);
    lit("clamp_hdr1", 1 + (18 + FE), 8'h1F);
    lit("clamp_hdr2", 1 + 2 * (18 + FE), 8'h17);
    chk("clamp_len", got_log.size(), 3 * (2 + FE) + 40);

    // Stall: out_ready toggles every cycle.
    start_test();
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) push_byte(2, 8'(8'h20 + i));
    build_expected();
    drain("toggle", 500);
    lit("toggle_hdr", 1, 8'h24);
    lit("toggle_last", 6, 8'h24);
    rdy_mode = 0;

    // Reset mid-frame after the second of five payload bytes.
    start_test();
    for (int i = 0; i < 5; i++) push_byte(0, 8'(8'h50 + i));
    build_expected();
    base = pop_total[0];
    n = 0;
    while (pop_total[0] - base < 2 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("rst_wait", int'(n < 200), 1);
    rstn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ch_ready", ch_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk); #1;
    chk("midrst_ch_ready_next", ch_ready, 0);
    chk("midrst_busy_next", busy, 0);
    exp_q.delete();
    got_log.delete();
    model_ptr = NCH - 1;
    push_byte(1, 8'h61); push_byte(1, 8'h62);
    build_expected();
    @(posedge clk); #2 rstn = 1'b1;
    drain("after_rst", 500);
    lit("after_rst_hdr0", 1, 8'h02);
    lit("after_rst_b0", 2, 8'h52);
    lit("after_rst_hdr1", 1 + (5 + FE), 8'h11);

    // Random mixed traffic with producer and sink stalls.
    rdy_mode = 2;
    vld_drop = 1'b1;
    for (int r = 0; r < 3; r++) begin
      start_test();
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, 20);
        for (int j = 0; j < n; j++) push_byte(c, 8'($urandom_range(0, 255)));
      end
      build_expected();
      drain("random", 3000);
    end
    rdy_mode = 0;
    vld_drop = 1'b0;

    // Single byte frame (CRC byte when enabled).
    start_test();
    push_byte(0, 8'h01);
    build_expected();
    drain("single", 300);
    lit("single_b0", 0, 8'hA5);
    lit("single_b1", 1, 8'h00);
    lit("single_b2", 2, 8'h01);
`ifdef USB_TX_ARB_CRC_EN
    lit("single_crc", 3, 8'h07);
`endif
    chk("single_len", got_log.size(), 3 + FE);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
